// File: rtl/basemul_pipe.sv
// basemul_pipe -- pipelined Kyber degree-1 base multiplier with optional
// multiply-accumulate and final Barrett reduction.
//
// Each beat carries LANES independent coefficient pairs. For every lane:
//   r0 = fqmul(fqmul(a1,b1), z) + fqmul(a0,b0) [+ c0]
//   r1 = fqmul(a0,b1) + fqmul(a1,b0)           [+ c1]
// where z = in_neg ? -zeta : zeta and all sums wrap at 16 bits. When
// REDUCE=1 both sums pass through a Barrett reduction.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready input handshake; in_ready is combinational
//   in_acc, in_neg    per-beat accumulate enable and twiddle negate
//   in_last           sideband tag, delivered on out_last with its beat
//   a, b, c           LANES x {hi,lo} signed 16-bit pairs, lane 0 in low bits
//   zeta              signed Montgomery-domain twiddle shared by all lanes
//   out_valid/out_ready/out_last/r  output handshake, tag and results
//   busy              any stage holds a valid beat
//
// Handshake: a beat moves across an interface on a clock edge where both
// valid and ready are high. The whole pipeline advances together on
// en = !out_valid || out_ready; when en is low every stage (data and valid)
// holds, so r/out_last stay stable while out_valid is high and out_ready low.
//
// Stages: S1 products and z, S2 Montgomery reduce, S3 multiply by z,
// S4 reduce, S5 sum/accumulate, S6 Barrett (only when REDUCE=1).
// Latency from accept to out_valid is 5 + REDUCE cycles.
module basemul_pipe #(
  parameter int LANES  = 2,
  parameter int REDUCE = 1,
  parameter int Q      = 3329,
  parameter int QINV   = -3327
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_acc,
  input  logic                  in_neg,
  input  logic                  in_last,
  input  logic [LANES*32-1:0]   a,
  input  logic [LANES*32-1:0]   b,
  input  logic [LANES*32-1:0]   c,
  input  logic [15:0]           zeta,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [LANES*32-1:0]   r,
  output logic                  busy
);

  localparam int W = LANES * 32;
  localparam logic signed [31:0] Q_W         = 32'(Q);
  localparam logic signed [31:0] QINV_W      = 32'(QINV);
  localparam logic signed [31:0] BARRETT_V   = 32'sd20159;
  localparam logic signed [31:0] BARRETT_RND = 32'sd33554432;

  // Sign-extend a 16-bit coefficient to a signed 32-bit operand.
  function automatic logic signed [31:0] sx(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  // Montgomery reduction: t = low16(p*QINV) (signed), result = (p - t*Q) >>> 16.
  // Only the low 16 bits of p*QINV matter, so the 32-bit wrap is harmless.
  function automatic logic [15:0] mont_reduce(input logic signed [31:0] p);
    logic [15:0] t;
    t = 16'(p * QINV_W);
    return 16'((p - sx(t) * Q_W) >>> 16);
  endfunction

  // Barrett reduction: x - ((20159*x + 2^25) >>> 26) * Q.
  function automatic logic [15:0] barrett(input logic [15:0] x);
    logic signed [31:0] xe;
    xe = sx(x);
    return 16'(xe - ((BARRETT_V * xe + BARRETT_RND) >>> 26) * Q_W);
  endfunction

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // ---------------------------------------------------------------- S1
  logic                s1_valid, s1_last, s1_acc;
  logic [W-1:0]        s1_c;
  logic [15:0]         s1_z;
  logic signed [31:0]  s1_p00 [LANES];
  logic signed [31:0]  s1_p01 [LANES];
  logic signed [31:0]  s1_p10 [LANES];
  logic signed [31:0]  s1_p11 [LANES];

  always_ff @(posedge clk or negedge rst_n) begin : p_s1
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_acc   <= 1'b0;
      s1_c     <= '0;
      s1_z     <= '0;
      for (int l = 0; l < LANES; l++) begin
        s1_p00[l] <= '0;
        s1_p01[l] <= '0;
        s1_p10[l] <= '0;
        s1_p11[l] <= '0;
      end
    end else if (en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_last <= in_last;
        s1_acc  <= in_acc;
        s1_c    <= c;
        // The odd pair of a Kyber quad uses -zeta; negation wraps at 16 bits.
        s1_z    <= in_neg ? (16'd0 - zeta) : zeta;
        for (int l = 0; l < LANES; l++) begin
          s1_p00[l] <= sx(a[l*32 +: 16])      * sx(b[l*32 +: 16]);
          s1_p01[l] <= sx(a[l*32 +: 16])      * sx(b[l*32+16 +: 16]);
          s1_p10[l] <= sx(a[l*32+16 +: 16])   * sx(b[l*32 +: 16]);
          s1_p11[l] <= sx(a[l*32+16 +: 16])   * sx(b[l*32+16 +: 16]);
        end
      end
    end
  end

  // ---------------------------------------------------------------- S2
  logic          s2_valid, s2_last, s2_acc;
  logic [W-1:0]  s2_c;
  logic [15:0]   s2_z;
  logic [15:0]   s2_m00 [LANES];
  logic [15:0]   s2_m01 [LANES];
  logic [15:0]   s2_m10 [LANES];
  logic [15:0]   s2_m11 [LANES];

  always_ff @(posedge clk or negedge rst_n) begin : p_s2
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_acc   <= 1'b0;
      s2_c     <= '0;
      s2_z     <= '0;
      for (int l = 0; l < LANES; l++) begin
        s2_m00[l] <= '0;
        s2_m01[l] <= '0;
        s2_m10[l] <= '0;
        s2_m11[l] <= '0;
      end
    end else if (en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_last <= s1_last;
        s2_acc  <= s1_acc;
        s2_c    <= s1_c;
        s2_z    <= s1_z;
        for (int l = 0; l < LANES; l++) begin
          s2_m00[l] <= mont_reduce(s1_p00[l]);
          s2_m01[l] <= mont_reduce(s1_p01[l]);
          s2_m10[l] <= mont_reduce(s1_p10[l]);
          s2_m11[l] <= mont_reduce(s1_p11[l]);
        end
      end
    end
  end

  // ---------------------------------------------------------------- S3
  logic                s3_valid, s3_last, s3_acc;
  logic [W-1:0]        s3_c;
  logic [15:0]         s3_m00 [LANES];
  logic [15:0]         s3_m01 [LANES];
  logic [15:0]         s3_m10 [LANES];
  logic signed [31:0]  s3_p11z [LANES];

  always_ff @(posedge clk or negedge rst_n) begin : p_s3
    if (!rst_n) begin
      s3_valid <= 1'b0;
      s3_last  <= 1'b0;
      s3_acc   <= 1'b0;
      s3_c     <= '0;
      for (int l = 0; l < LANES; l++) begin
        s3_m00[l]  <= '0;
        s3_m01[l]  <= '0;
        s3_m10[l]  <= '0;
        s3_p11z[l] <= '0;
      end
    end else if (en) begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_last <= s2_last;
        s3_acc  <= s2_acc;
        s3_c    <= s2_c;
        for (int l = 0; l < LANES; l++) begin
          s3_m00[l]  <= s2_m00[l];
          s3_m01[l]  <= s2_m01[l];
          s3_m10[l]  <= s2_m10[l];
          s3_p11z[l] <= sx(s2_m11[l]) * sx(s2_z);
        end
      end
    end
  end

  // ---------------------------------------------------------------- S4
  logic          s4_valid, s4_last, s4_acc;
  logic [W-1:0]  s4_c;
  logic [15:0]   s4_m00  [LANES];
  logic [15:0]   s4_m01  [LANES];
  logic [15:0]   s4_m10  [LANES];
  logic [15:0]   s4_m11z [LANES];

  always_ff @(posedge clk or negedge rst_n) begin : p_s4
    if (!rst_n) begin
      s4_valid <= 1'b0;
      s4_last  <= 1'b0;
      s4_acc   <= 1'b0;
      s4_c     <= '0;
      for (int l = 0; l < LANES; l++) begin
        s4_m00[l]  <= '0;
        s4_m01[l]  <= '0;
        s4_m10[l]  <= '0;
        s4_m11z[l] <= '0;
      end
    end else if (en) begin
      s4_valid <= s3_valid;
      if (s3_valid) begin
        s4_last <= s3_last;
        s4_acc  <= s3_acc;
        s4_c    <= s3_c;
        for (int l = 0; l < LANES; l++) begin
          s4_m00[l]  <= s3_m00[l];
          s4_m01[l]  <= s3_m01[l];
          s4_m10[l]  <= s3_m10[l];
          s4_m11z[l] <= mont_reduce(s3_p11z[l]);
        end
      end
    end
  end

  // ---------------------------------------------------------------- S5
  logic          s5_valid, s5_last;
  logic [W-1:0]  s5_r;
  logic [W-1:0]  sum_next;

  // Plain 16-bit adds: wrap-around is the intended arithmetic here.
  always_comb begin : p_sum
    sum_next = '0;
    for (int l = 0; l < LANES; l++) begin
      sum_next[l*32 +: 16]    = s4_m11z[l] + s4_m00[l]
                              + (s4_acc ? s4_c[l*32 +: 16] : 16'd0);
      sum_next[l*32+16 +: 16] = s4_m01[l] + s4_m10[l]
                              + (s4_acc ? s4_c[l*32+16 +: 16] : 16'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : p_s5
    if (!rst_n) begin
      s5_valid <= 1'b0;
      s5_last  <= 1'b0;
      s5_r     <= '0;
    end else if (en) begin
      s5_valid <= s4_valid;
      if (s4_valid) begin
        s5_last <= s4_last;
        s5_r    <= sum_next;
      end
    end
  end

  // ---------------------------------------------------------------- S6
  logic tail_valid;

  if (REDUCE != 0) begin : g_reduce
    logic          s6_valid, s6_last;
    logic [W-1:0]  s6_r;
    logic [W-1:0]  red_next;

    always_comb begin : p_red
      red_next = '0;
      for (int l = 0; l < LANES; l++) begin
        red_next[l*32 +: 16]    = barrett(s5_r[l*32 +: 16]);
        red_next[l*32+16 +: 16] = barrett(s5_r[l*32+16 +: 16]);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_s6
      if (!rst_n) begin
        s6_valid <= 1'b0;
        s6_last  <= 1'b0;
        s6_r     <= '0;
      end else if (en) begin
        s6_valid <= s5_valid;
        if (s5_valid) begin
          s6_last <= s5_last;
          s6_r    <= red_next;
        end
      end
    end

    assign out_valid  = s6_valid;
    assign out_last   = s6_last;
    assign r          = s6_r;
    assign tail_valid = s6_valid;
  end else begin : g_raw
    assign out_valid  = s5_valid;
    assign out_last   = s5_last;
    assign r          = s5_r;
    assign tail_valid = 1'b0;
  end

  assign busy = s1_valid | s2_valid | s3_valid | s4_valid | s5_valid | tail_valid;

endmodule

// File: tb/tb_basemul_pipe.sv
// Bench for basemul_pipe. Two instances share one stimulus bus: u_dut0
// (LANES=2, REDUCE=0) and u_dut1 (LANES=4, REDUCE=1); 'sel' picks which one
// a test talks to, the other sees in_valid=0 and out_ready=1.
module tb_basemul_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         sel;
  logic         in_valid, in_acc, in_neg, in_last, out_ready;
  logic [15:0]  zeta;
  logic [127:0] a, b, c;

  logic         in_ready0, out_valid0, out_last0, busy0;
  logic [63:0]  r0;
  logic         in_ready1, out_valid1, out_last1, busy1;
  logic [127:0] r1;

  logic         o_in_ready, o_out_valid, o_last, o_busy;
  logic [127:0] o_r;

  logic [128:0] exp_q[$];
  int n_vec, n_err;

  basemul_pipe #(.LANES(2), .REDUCE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & ~sel), .in_ready(in_ready0),
    .in_acc(in_acc), .in_neg(in_neg), .in_last(in_last),
    .a(a[63:0]), .b(b[63:0]), .c(c[63:0]), .zeta(zeta),
    .out_valid(out_valid0), .out_ready(out_ready | sel), .out_last(out_last0),
    .r(r0), .busy(busy0)
  );

  basemul_pipe #(.LANES(4), .REDUCE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & sel), .in_ready(in_ready1),
    .in_acc(in_acc), .in_neg(in_neg), .in_last(in_last),
    .a(a), .b(b), .c(c), .zeta(zeta),
    .out_valid(out_valid1), .out_ready(out_ready | ~sel), .out_last(out_last1),
    .r(r1), .busy(busy1)
  );

  assign o_in_ready  = sel ? in_ready1  : in_ready0;
  assign o_out_valid = sel ? out_valid1 : out_valid0;
  assign o_last      = sel ? out_last1  : out_last0;
  assign o_busy      = sel ? busy1      : busy0;
  assign o_r         = sel ? r1         : {64'd0, r0};

  // ------------------------------------------------ reference model
  function automatic shortint fq(input int x, input int y);
    longint p, d;
    shortint t;
    p = longint'(x) * longint'(y);
    t = shortint'(p * (-3327));
    d = p - longint'(t) * 3329;
    return shortint'(d / 65536);  // d is an exact multiple of 2^16
  endfunction

  function automatic shortint barrett_ref(input shortint x);
    longint v, k;
    v = longint'(x) * 20159 + 33554432;
    k = v >>> 26;
    return shortint'(longint'(x) - k * 3329);
  endfunction

  // s=0 -> 2 lanes, raw sums; s=1 -> 4 lanes, reduced sums.
  function automatic logic [127:0] model(input logic [127:0] av, bv, cv,
                                         input logic [15:0] zv,
                                         input logic neg, acc, s);
    logic [127:0] res;
    shortint a0, a1, b0, b1, c0, c1, s0, s1, z;
    res = '0;
    z = neg ? shortint'(-int'($signed(zv))) : $signed(zv);
    for (int l = 0; l < (s ? 4 : 2); l++) begin
      a0 = $signed(av[l*32 +: 16]);  a1 = $signed(av[l*32+16 +: 16]);
      b0 = $signed(bv[l*32 +: 16]);  b1 = $signed(bv[l*32+16 +: 16]);
      c0 = $signed(cv[l*32 +: 16]);  c1 = $signed(cv[l*32+16 +: 16]);
      s0 = shortint'(int'(fq(fq(a1, b1), z)) + int'(fq(a0, b0)) + (acc ? int'(c0) : 0));
      s1 = shortint'(int'(fq(a0, b1)) + int'(fq(a1, b0)) + (acc ? int'(c1) : 0));
      if (s) begin
        s0 = barrett_ref(s0);
        s1 = barrett_ref(s1);
      end
      res[l*32 +: 16]    = s0;
      res[l*32+16 +: 16] = s1;
    end
    return res;
  endfunction

  // ------------------------------------------------ driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_beat();
    a      = {$urandom, $urandom, $urandom, $urandom};
    b      = {$urandom, $urandom, $urandom, $urandom};
    c      = {$urandom, $urandom, $urandom, $urandom};
    zeta   = 16'($urandom);
    in_neg = 1'($urandom);
    in_acc = 1'($urandom);
  endtask

  // Sends one beat into an idle pipeline and watches 20 cycles of output.
  task automatic send_one(input logic [127:0] av, bv, cv, input logic [15:0] zv,
                          input logic neg, acc, last,
                          output int lat, output int nvalid,
                          output logic [127:0] robs, output logic lobs);
    lat = -1; nvalid = 0; robs = '0; lobs = 1'b0;
    a = av; b = bv; c = cv; zeta = zv; in_neg = neg; in_acc = acc; in_last = last;
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      #1;
      if (o_out_valid) begin
        if (lat < 0) begin
          lat = k; robs = o_r; lobs = o_last;
        end
        nvalid++;
      end
      tick();
    end
  endtask

  // ------------------------------------------------ tests
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      n_vec++; if (o_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid sel=%0d: got %b want 0", s, o_out_valid); end
      n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy sel=%0d: got %b want 0", s, o_busy); end
      n_vec++; if (o_r !== 128'd0) begin n_err++; $display("FAIL reset_r sel=%0d: got %h want 0", s, o_r); end
      n_vec++; if (o_last !== 1'b0) begin n_err++; $display("FAIL reset_out_last sel=%0d: got %b want 0", s, o_last); end
      n_vec++; if (o_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready sel=%0d: got %b want 1", s, o_in_ready); end
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_identity();
    int lat, nv; logic [127:0] ro; logic lo; logic [15:0] zv;
    sel = 1'b0;
    zv = 16'($urandom);
    send_one(128'h1, 128'h1, 128'h0, zv, 1'b0, 1'b0, 1'b1, lat, nv, ro, lo);
    n_vec++; if (lat !== 5) begin n_err++; $display("FAIL identity_latency: got %0d want 5", lat); end
    n_vec++; if (nv !== 1) begin n_err++; $display("FAIL identity_valid_cycles: got %0d want 1", nv); end
    n_vec++; if (ro !== 128'h0000_00a9) begin n_err++; $display("FAIL identity_r: got %h want %h", ro, 128'h0000_00a9); end
    n_vec++; if (lo !== 1'b1) begin n_err++; $display("FAIL identity_last: got %b want 1", lo); end
  endtask

  task automatic test_twiddle();
    int lat, nv; logic [127:0] ro, ex; logic lo;
    sel = 1'b0;
    send_one(128'h0001_0000, 128'h0001_0000, 128'h0, 16'd1, 1'b0, 1'b0, 1'b0, lat, nv, ro, lo);
    n_vec++; if (ro !== 128'h0000_fa88) begin n_err++; $display("FAIL twiddle_pos: got %h want %h", ro, 128'h0000_fa88); end
    send_one(128'h0001_0000, 128'h0001_0000, 128'h0, 16'd1, 1'b1, 1'b0, 1'b0, lat, nv, ro, lo);
    n_vec++; if (ro !== 128'h0000_0578) begin n_err++; $display("FAIL twiddle_neg: got %h want %h", ro, 128'h0000_0578); end
    n_vec++; if (lo !== 1'b0) begin n_err++; $display("FAIL twiddle_last: got %b want 0", lo); end
    // Random twiddle on the reduced 4-lane instance.
    sel = 1'b1;
    rand_beat();
    ex = model(a, b, c, zeta, 1'b1, 1'b0, 1'b1);
    send_one(a, b, c, zeta, 1'b1, 1'b0, 1'b0, lat, nv, ro, lo);
    n_vec++; if (ro !== ex) begin n_err++; $display("FAIL twiddle_rand: got %h want %h", ro, ex); end
  endtask

  task automatic test_accumulate();
    int lat, nv; logic [127:0] ro; logic lo;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      send_one(128'h0001_0000, 128'h0001_0000, 128'h00c8_0064, 16'd1, 1'b0, 1'b1, 1'b0,
               lat, nv, ro, lo);
      n_vec++; if (ro !== 128'h00c8_faec) begin n_err++; $display("FAIL acc_r sel=%0d: got %h want %h", s, ro, 128'h00c8_faec); end
      n_vec++; if (lat !== 5 + s) begin n_err++; $display("FAIL acc_latency sel=%0d: got %0d want %0d", s, lat, 5 + s); end
    end
  endtask

  task automatic test_lanes();
    int lat, nv; logic [127:0] ro, ex; logic lo;
    sel = 1'b1;
    rand_beat();
    ex = model(a, b, c, zeta, in_neg, in_acc, 1'b1);
    send_one(a, b, c, zeta, in_neg, in_acc, 1'b0, lat, nv, ro, lo);
    for (int l = 0; l < 4; l++) begin
      n_vec++;
      if (ro[l*32 +: 32] !== ex[l*32 +: 32]) begin
        n_err++; $display("FAIL lane_%0d: got %h want %h", l, ro[l*32 +: 32], ex[l*32 +: 32]);
      end
    end
    // Only lane 2 carries data; every other lane must come out zero.
    rand_beat();
    a = a & {32'd0, 32'hffff_ffff, 64'd0};
    b = b & {32'd0, 32'hffff_ffff, 64'd0};
    ex = model(a, b, c, zeta, in_neg, 1'b0, 1'b1);
    send_one(a, b, c, zeta, in_neg, 1'b0, 1'b0, lat, nv, ro, lo);
    n_vec++; if (ro !== ex) begin n_err++; $display("FAIL lane_isolation: got %h want %h", ro, ex); end
    n_vec++; if (lat !== 6) begin n_err++; $display("FAIL lane_latency: got %0d want 6", lat); end
  endtask

  task automatic test_back_to_back(input logic s);
    int sent, got; logic [128:0] e; bit stall, have;
    sel = s; exp_q.delete(); sent = 0; got = 0; have = 0;
    for (int cyc = 0; cyc < 100 && got < 16; cyc++) begin
      stall = (cyc >= 8 && cyc <= 10);
      out_ready = !stall;
      if (sent < 16) begin
        if (!have) begin rand_beat(); in_last = (sent == 15); have = 1; end
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (sent < 16) begin
        n_vec++; if (o_in_ready !== !stall) begin n_err++; $display("FAIL b2b_in_ready sel=%0d cyc=%0d: got %b want %b", s, cyc, o_in_ready, !stall); end
      end
      if (stall) begin
        n_vec++; if (o_out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_stall_valid sel=%0d cyc=%0d: got %b want 1", s, cyc, o_out_valid); end
        n_vec++;
        if (exp_q.size() == 0 || o_r !== exp_q[0][127:0]) begin
          n_err++; $display("FAIL b2b_stall_r sel=%0d cyc=%0d: got %h", s, cyc, o_r);
        end
      end
      if (in_valid && o_in_ready) begin
        exp_q.push_back({in_last, model(a, b, c, zeta, in_neg, in_acc, s)});
        sent++; have = 0;
      end
      if (o_out_valid && out_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL b2b_spurious sel=%0d: got %h want none", s, o_r);
        end else begin
          e = exp_q.pop_front();
          if ({o_last, o_r} !== e) begin n_err++; $display("FAIL b2b_result sel=%0d beat=%0d: got %h want %h", s, got, {o_last, o_r}, e); end
        end
        got++;
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    n_vec++; if (got !== 16) begin n_err++; $display("FAIL b2b_count sel=%0d: got %0d want 16", s, got); end
    n_vec++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL b2b_leftover sel=%0d: got %0d want 0", s, exp_q.size()); end
    n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL b2b_busy_end sel=%0d: got %b want 0", s, o_busy); end
    tick();
  endtask

  task automatic test_random(input logic s);
    int sent, got; logic [128:0] e; bit have;
    sel = s; exp_q.delete(); sent = 0; got = 0; have = 0;
    for (int cyc = 0; cyc < 600 && got < 40; cyc++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      if (sent < 40) begin
        if (!have) begin rand_beat(); in_last = 1'($urandom); have = 1; end
        in_valid = ($urandom_range(0, 9) < 7);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (o_out_valid && !out_ready) begin
        n_vec++;
        if (exp_q.size() == 0 || o_r !== exp_q[0][127:0] || o_in_ready !== 1'b0) begin
          n_err++; $display("FAIL rand_hold sel=%0d cyc=%0d: got r=%h in_ready=%b", s, cyc, o_r, o_in_ready);
        end
      end
      if (in_valid && o_in_ready) begin
        exp_q.push_back({in_last, model(a, b, c, zeta, in_neg, in_acc, s)});
        sent++; have = 0;
      end
      if (o_out_valid && out_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL rand_spurious sel=%0d: got %h want none", s, o_r);
        end else begin
          e = exp_q.pop_front();
          if ({o_last, o_r} !== e) begin n_err++; $display("FAIL rand_result sel=%0d beat=%0d: got %h want %h", s, got, {o_last, o_r}, e); end
        end
        got++;
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_vec++; if (got !== 40) begin n_err++; $display("FAIL rand_count sel=%0d: got %0d want 40", s, got); end
  endtask

  task automatic test_reset_midstream();
    int k, lat, nv; logic [127:0] ro, ex; logic lo;
    sel = 1'b1; exp_q.delete(); out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_beat(); in_last = 1'b0; in_valid = 1'b1;
      #1;
      if (o_in_ready) exp_q.push_back({1'b0, model(a, b, c, zeta, in_neg, in_acc, 1'b1)});
      tick();
    end
    in_valid = 1'b0;
    k = 0;
    while (!o_out_valid && k < 10) begin tick(); k++; end
    n_vec++; if (o_out_valid !== 1'b1) begin n_err++; $display("FAIL mid_first_out: got %b want 1 within 10 cycles", o_out_valid); end
    out_ready = 1'b0;
    #1;
    n_vec++;
    if (exp_q.size() == 0 || o_r !== exp_q[0][127:0]) begin n_err++; $display("FAIL mid_first_r: got %h", o_r); end
    #1 rst_n = 1'b0;
    #1;
    n_vec++; if (o_out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b want 0", o_out_valid); end
    n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %b want 0", o_busy); end
    n_vec++; if (o_r !== 128'd0) begin n_err++; $display("FAIL mid_rst_r: got %h want 0", o_r); end
    n_vec++; if (o_last !== 1'b0) begin n_err++; $display("FAIL mid_rst_last: got %b want 0", o_last); end
    tick(); tick();
    rst_n = 1'b1; out_ready = 1'b1; exp_q.delete();
    for (int i = 0; i < 12; i++) begin
      #1;
      n_vec++; if (o_out_valid !== 1'b0) begin n_err++; $display("FAIL mid_stale cyc=%0d: got %b want 0", i, o_out_valid); end
      tick();
    end
    rand_beat();
    ex = model(a, b, c, zeta, in_neg, in_acc, 1'b1);
    send_one(a, b, c, zeta, in_neg, in_acc, 1'b1, lat, nv, ro, lo);
    n_vec++; if (lat !== 6) begin n_err++; $display("FAIL mid_new_latency: got %0d want 6", lat); end
    n_vec++; if ({lo, ro} !== {1'b1, ex}) begin n_err++; $display("FAIL mid_new_r: got %h want %h", {lo, ro}, {1'b1, ex}); end
  endtask

  // ------------------------------------------------ sequence + report
  initial begin
    n_vec = 0; n_err = 0;
    sel = 1'b0; rst_n = 1'b0;
    in_valid = 1'b0; in_acc = 1'b0; in_neg = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    zeta = '0; a = '0; b = '0; c = '0;
    test_reset();
    test_identity();
    test_twiddle();
    test_accumulate();
    test_lanes();
    test_back_to_back(1'b0);
    test_back_to_back(1'b1);
    test_random(1'b0);
    test_random(1'b1);
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/basemul_pipe.md
Name: basemul_pipe

Overview:
- Fully pipelined, parametrised successor to the single-pair iterative base multiplier of the Kyber NTT datapath.
- Processes LANES independent degree-1 base multiplications per beat, one beat per cycle, under valid/ready flow control.
- Supports a multiply-accumulate mode (r = c + a*b mod (X^2 - zeta)) for matrix-vector products over K polynomials, with optional final Barrett reduction.
- Sits between coefficient RAM read ports and the accumulator/write-back path.

Parameters:
LANES, 2, number of base-multiplication pairs processed per beat (>=1)
REDUCE, 1, 1 = Barrett-reduce the final sums; 0 = raw 16-bit wrapped sums
Q, 3329, modulus
QINV, -3327, q^-1 mod 2^16 as signed 16-bit, used in Montgomery reduction

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  block accepts a beat this cycle
in_acc  in  1  1 = add c to result; 0 = ignore c
in_neg  in  1  1 = use -zeta for this beat (odd pair of a Kyber quad)
in_last  in  1  tag marking last beat of a polynomial, passed through
a  in  LANES*2*16  signed coefficient pairs {a1,a0} per lane
b  in  LANES*2*16  signed coefficient pairs {b1,b0} per lane
c  in  LANES*2*16  signed accumulator pairs {c1,c0} per lane
zeta  in  16  signed Montgomery-domain twiddle, shared by all lanes
out_valid  out  1  result beat valid
out_ready  in  1  downstream accepts a beat
out_last  out  1  in_last of the beat now on r
r  out  LANES*2*16  signed result pairs {r1,r0} per lane
busy  out  1  any pipeline stage holds a valid beat

Behaviour:
- fqmul(x,y) = montgomery(x*y): p = 32-bit signed product; t = low 16 bits of p*QINV, as signed; result = (p - t*Q) >>> 16, 16-bit signed.
- Per lane: r0 = fqmul(fqmul(a1,b1), z) + fqmul(a0,b0); r1 = fqmul(a0,b1) + fqmul(a1,b0). z = in_neg ? -zeta : zeta.
- If in_acc, add c0/c1 to r0/r1. All additions are 16-bit two's-complement wrap.
- If REDUCE=1: r = x - ((20159*x + 2^25) >>> 26)*Q, 16-bit signed.
- Pipeline stages:
  - S1: four products, plus z.
  - S2: Montgomery reduce all four.
  - S3: multiply a1b1 by z.
  - S4: reduce.
  - S5: sum and accumulate.
  - S6: Barrett, present only when REDUCE=1.
- Latency LAT = 5 + REDUCE cycles from accept to out_valid, absent stalls.
- Control fields (acc, c, last) travel with their data through every stage.
- Global advance enable: en = !out_valid || out_ready. in_ready = en (combinational).
- A beat is accepted when in_valid && in_ready. When en=0, every stage register and every valid bit hold, so r and out_last are stable while out_valid && !out_ready.
- Per-stage valid bits; bubbles propagate as invalid stages; no reordering.
- A transfer occurs when out_valid && out_ready. Accept and output may occur in the same cycle; throughput is 1 beat/cycle.
- busy = OR of all stage valid bits.
- Reset (rst_n low, any time, including mid-stream): all valid bits = 0, out_valid = 0, out_last = 0, r = 0, all data registers = 0. In-flight beats are discarded.
- First accept is possible in the cycle after rst_n deasserts.
- Inputs are ignored while in_ready = 0 or in_valid = 0.
- Lanes are independent; zeta, in_neg, in_acc and in_last are common to all lanes of a beat.

Test Plan:
- Identity (REDUCE=0, in_acc=0): lane0 a=(1,0), b=(1,0), any zeta -> after 5 cycles r0=169, r1=0, out_valid=1 for exactly 1 cycle.
- Twiddle path: a=(0,1), b=(0,1), zeta=1, in_neg=0 -> r0=-1400, r1=0. Same beat with in_neg=1 -> r0=1400.
- Accumulate: previous beat with in_acc=1, c=(100,200) -> r0=-1300, r1=200. With REDUCE=1 -> identical values, latency 6.
- Streaming plus backpressure: 16 back-to-back random beats, out_ready held low for cycles 8-10 -> in_ready=0 during stall, r stable. All 16 results match the C reference in order, no loss or duplication. out_last appears only on beat 16.
- Reset mid-stream: assert rst_n low with 3 beats in flight -> out_valid=0, busy=0, r=0 immediately (asynchronously). After release, no stale beat emerges and a new beat returns after LAT cycles.
- Lane independence (LANES=4): distinct random a/b per lane -> each lane matches the reference, with no cross-lane corruption.
